// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//   Parallel-in / serial-out converter. Accepts WIDTH-bit words over a
//   valid/ready handshake and emits them one bit per clock on sout, with
//   gapless back-to-back words at full rate. The serial line is held at 0
//   whenever no word bit is being transmitted.
//
// Parameters
//   WIDTH      word length in bits (legal range 2..32)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//
// Ports
//   clk         clock, all state on posedge
//   rst         synchronous active-high reset
//   in_data     parallel word to serialize
//   in_valid    in_data is valid this cycle
//   in_ready    block can accept a word this cycle (from state only)
//   sout        serial data bit (0 when sout_valid is low)
//   sout_valid  sout carries a word bit this cycle
//   word_done   final bit of a word is on sout this cycle
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             word_done
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    logic             at_last;
    logic             accept;
    logic             head_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // Handshake and last-bit decode; depends on registered state only.
    always_comb begin
        at_last  = (state == SHIFT) && (cnt == LAST_CNT);
        in_ready = (state == IDLE) || at_last;
        accept   = in_valid && in_ready;
    end

    // Bit-order selection: the outgoing bit and the zero-filled shift.
    always_comb begin
        head_bit      = 1'b0;
        shreg_shifted = '0;
        if (MSB_FIRST) begin
            head_bit      = shreg[WIDTH-1];
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            head_bit      = shreg[0];
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // Serial outputs are pure functions of registered state; sout is gated
    // so the line is a defined 0 outside of a word.
    always_comb begin
        sout_valid = (state == SHIFT);
        sout       = (state == SHIFT) && head_bit;
        word_done  = at_last;
    end

    // State machine, shift register and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg <= in_data;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (at_last) begin
                        if (accept) begin
                            // Reload on the last bit keeps the stream gapless.
                            shreg <= in_data;
                            cnt   <= '0;
                        end else begin
                            shreg <= '0;
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end else begin
                        shreg <= shreg_shifted;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       sout;
    logic       sout_valid;
    logic       word_done;

    logic [2:0] in_data3;
    logic       in_valid3;
    logic       in_ready3;
    logic       sout3;
    logic       sout_valid3;
    logic       word_done3;

    int vectors;
    int miscompares;
    bit mon_en;

    // Expected serial stream entries: {word_done, sout}
    logic [1:0] q8[$];
    logic [1:0] q3[$];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .word_done  (word_done)
    );

    piso_serializer #(.WIDTH(3), .MSB_FIRST(1'b0)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data3),
        .in_valid   (in_valid3),
        .in_ready   (in_ready3),
        .sout       (sout3),
        .sout_valid (sout_valid3),
        .word_done  (word_done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // Scoreboard: every cycle, pop expected bits while valid, demand a clean line otherwise.
    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            vectors++;
            if (sout_valid === 1'b1) begin
                if (q8.size() == 0) begin
                    miscompares++;
                    $display("FAIL w8_extra_bit: sout_valid=1 sout=%b, required no word bit", sout);
                end else begin
                    e = q8.pop_front();
                    if (sout !== e[0] || word_done !== e[1]) begin
                        miscompares++;
                        $display("FAIL w8_bit: sout=%b word_done=%b, required sout=%b word_done=%b",
                                 sout, word_done, e[0], e[1]);
                    end
                end
            end else if (sout !== 1'b0 || word_done !== 1'b0 || sout_valid !== 1'b0 || q8.size() != 0) begin
                miscompares++;
                $display("FAIL w8_idle: sout_valid=%b sout=%b word_done=%b pending=%0d, required 0 0 0 with no pending bits",
                         sout_valid, sout, word_done, q8.size());
            end

            vectors++;
            if (sout_valid3 === 1'b1) begin
                if (q3.size() == 0) begin
                    miscompares++;
                    $display("FAIL w3_extra_bit: sout_valid=1 sout=%b, required no word bit", sout3);
                end else begin
                    e = q3.pop_front();
                    if (sout3 !== e[0] || word_done3 !== e[1]) begin
                        miscompares++;
                        $display("FAIL w3_bit: sout=%b word_done=%b, required sout=%b word_done=%b",
                                 sout3, word_done3, e[0], e[1]);
                    end
                end
            end else if (sout3 !== 1'b0 || word_done3 !== 1'b0 || sout_valid3 !== 1'b0 || q3.size() != 0) begin
                miscompares++;
                $display("FAIL w3_idle: sout_valid=%b sout=%b word_done=%b pending=%0d, required 0 0 0 with no pending bits",
                         sout_valid3, sout3, word_done3, q3.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // MSB-first expectation for the 8-bit instance.
    task automatic push8(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) q8.push_back({(i == 0), w[i]});
    endtask

    // LSB-first expectation for the 3-bit instance.
    task automatic push3(input logic [2:0] w);
        for (int i = 0; i < 3; i++) q3.push_back({(i == 2), w[i]});
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_valid3 = 1'b1;
        in_data3  = 3'b111;
        tick();
        tick();
        vectors++;
        if (in_ready !== 1'b1 || sout !== 1'b0 || sout_valid !== 1'b0 || word_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w8: in_ready=%b sout=%b sout_valid=%b word_done=%b, required 1 0 0 0",
                     in_ready, sout, sout_valid, word_done);
        end
        vectors++;
        if (in_ready3 !== 1'b1 || sout3 !== 1'b0 || sout_valid3 !== 1'b0 || word_done3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_w3: in_ready=%b sout=%b sout_valid=%b word_done=%b, required 1 0 0 0",
                     in_ready3, sout3, sout_valid3, word_done3);
        end
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        in_data   = 8'h00;
        in_data3  = 3'b000;
        tick();
        vectors++;
        if (sout_valid !== 1'b0 || sout_valid3 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_wins: sout_valid=%b/%b, required 0/0 (valid during reset must be dropped)",
                     sout_valid, sout_valid3);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_word();
        in_data  = 8'b1011_0100;
        in_valid = 1'b1;
        tick();
        push8(8'b1011_0100);
        in_valid = 1'b0;
        in_data  = 8'hFF;  // must not disturb the word in flight
        for (int c = 1; c <= 8; c++) begin
            vectors++;
            if (in_ready !== (c == 8)) begin
                miscompares++;
                $display("FAIL single_in_ready: cycle %0d in_ready=%b, required %b", c, in_ready, (c == 8));
            end
            tick();
        end
        vectors++;
        if (sout_valid !== 1'b0 || in_ready !== 1'b1 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL single_end: sout_valid=%b in_ready=%b pending=%0d, required 0 1 0",
                     sout_valid, in_ready, q8.size());
        end
        in_data = 8'h00;
    endtask

    task automatic test_back_to_back();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick();
        push8(8'hA5);
        in_data = 8'h3C;
        for (int c = 1; c <= 16; c++) begin
            vectors++;
            if (in_ready !== (c == 8 || c == 16) || sout_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_cycle: cycle %0d in_ready=%b sout_valid=%b, required %b 1",
                         c, in_ready, sout_valid, (c == 8 || c == 16));
            end
            tick();
            if (c == 8) begin
                push8(8'h3C);
                in_valid = 1'b0;
                in_data  = 8'h00;
            end
        end
        vectors++;
        if (sout_valid !== 1'b0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_end: sout_valid=%b pending=%0d, required 0 0", sout_valid, q8.size());
        end
    endtask

    task automatic test_busy_ignore();
        in_data  = 8'h00;
        in_valid = 1'b1;
        tick();
        push8(8'h00);
        in_valid = 1'b0;
        tick();
        tick();
        in_data  = 8'hFF;
        in_valid = 1'b1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_in_ready: in_ready=%b mid-word, required 0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (sout_valid !== 1'b0 || in_ready !== 1'b1 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL busy_end: sout_valid=%b in_ready=%b pending=%0d, required 0 1 0",
                     sout_valid, in_ready, q8.size());
        end
    endtask

    task automatic test_reset_mid_word();
        in_data  = 8'hF0;
        in_valid = 1'b1;
        tick();
        push8(8'hF0);
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        q8.delete();  // in-flight word is discarded
        rst = 1'b0;
        vectors++;
        if (sout_valid !== 1'b0 || sout !== 1'b0 || in_ready !== 1'b1 || word_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: sout_valid=%b sout=%b in_ready=%b word_done=%b, required 0 0 1 0",
                     sout_valid, sout, in_ready, word_done);
        end
        in_data  = 8'h81;
        in_valid = 1'b1;
        tick();
        push8(8'h81);
        in_valid = 1'b0;
        in_data  = 8'h00;
        vectors++;
        if (sout_valid !== 1'b1 || sout !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_restart: sout_valid=%b sout=%b, required 1 1", sout_valid, sout);
        end
        for (int i = 0; i < 8; i++) tick();
        vectors++;
        if (sout_valid !== 1'b0 || q8.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_end: sout_valid=%b pending=%0d, required 0 0", sout_valid, q8.size());
        end
    endtask

    task automatic test_lsb_first_w3();
        in_data3  = 3'b110;
        in_valid3 = 1'b1;
        tick();
        push3(3'b110);
        in_valid3 = 1'b0;
        in_data3  = 3'b000;
        for (int c = 1; c <= 3; c++) begin
            vectors++;
            if (in_ready3 !== (c == 3) || word_done3 !== (c == 3) || sout_valid3 !== 1'b1) begin
                miscompares++;
                $display("FAIL w3_cycle: cycle %0d in_ready=%b word_done=%b sout_valid=%b, required %b %b 1",
                         c, in_ready3, word_done3, sout_valid3, (c == 3), (c == 3));
            end
            tick();
        end
        vectors++;
        if (sout_valid3 !== 1'b0 || in_ready3 !== 1'b1 || q3.size() != 0) begin
            miscompares++;
            $display("FAIL w3_end: sout_valid=%b in_ready=%b pending=%0d, required 0 1 0",
                     sout_valid3, in_ready3, q3.size());
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        rst         = 1'b1;
        in_data     = 8'h00;
        in_valid    = 1'b0;
        in_data3    = 3'b000;
        in_valid3   = 1'b0;

        test_reset();
        test_single_word();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_word();
        test_lsb_first_w3();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
